// File: rtl/axi_slave_mem_param.sv
// AXI3 slave memory model with independent read and write channels.
// Supports FIXED/INCR/WRAP bursts, a configurable read latency and SLVERR
// for beats whose address lies beyond the modelled memory.
// Ports:
//   pll_core_cpuclk / pad_cpu_rst_b : clock, async active-low reset
//   ar*_s0 / r*_s0                  : read address and read data channels
//   aw*_s0 / w*_s0 / b*_s0          : write address, data and response channels
module axi_slave_mem_param #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned MEM_AW = 21,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                  pll_core_cpuclk,
  input  logic                  pad_cpu_rst_b,
  input  logic [ADDR_W-1:0]     araddr_s0,
  input  logic [ID_W-1:0]       arid_s0,
  input  logic [7:0]            arlen_s0,
  input  logic [2:0]            arsize_s0,
  input  logic [1:0]            arburst_s0,
  input  logic [3:0]            arcache_s0,
  input  logic [2:0]            arprot_s0,
  input  logic                  arvalid_s0,
  output logic                  arready_s0,
  input  logic [ADDR_W-1:0]     awaddr_s0,
  input  logic [ID_W-1:0]       awid_s0,
  input  logic [7:0]            awlen_s0,
  input  logic [2:0]            awsize_s0,
  input  logic [1:0]            awburst_s0,
  input  logic [3:0]            awcache_s0,
  input  logic [2:0]            awprot_s0,
  input  logic                  awvalid_s0,
  output logic                  awready_s0,
  input  logic [DATA_W-1:0]     wdata_s0,
  input  logic [DATA_W/8-1:0]   wstrb_s0,
  input  logic [ID_W-1:0]       wid_s0,
  input  logic                  wlast_s0,
  input  logic                  wvalid_s0,
  output logic                  wready_s0,
  output logic [ID_W-1:0]       bid_s0,
  output logic [1:0]            bresp_s0,
  output logic                  bvalid_s0,
  input  logic                  bready_s0,
  output logic [DATA_W-1:0]     rdata_s0,
  output logic [ID_W-1:0]       rid_s0,
  output logic [1:0]            rresp_s0,
  output logic                  rlast_s0,
  output logic                  rvalid_s0,
  input  logic                  rready_s0
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LOG_NB = $clog2(NB);
  localparam int unsigned HI     = LOG_NB + MEM_AW;  // lowest out-of-range address bit

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

  // Address of the beat following addr within the burst
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0] len,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    logic [2:0]        s;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] res;
    s    = (size > 3'(LOG_NB)) ? 3'(LOG_NB) : size;
    inc  = addr + (ADDR_W'(1) << s);
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << s) - ADDR_W'(1);
    res  = inc;
    if (burst == 2'b00) begin
      res = addr;
    end else if (burst == 2'b10 &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      res = (addr & ~mask) | (inc & mask);
    end
    return res;
  endfunction

  function automatic logic is_oor(input logic [ADDR_W-1:0] addr);
    return |(addr >> HI);
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[HI-1:LOG_NB];
  endfunction

  // Cache/prot, write ID and wlast carry no meaning for this model
  logic unused_in;
  assign unused_in = ^{arcache_s0, arprot_s0, awcache_s0, awprot_s0, wid_s0, wlast_s0};

  // ---------------------------------------------------------------- read side
  r_state_t          r_state, r_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_addr_nxt, r_load_addr;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size, lat_cnt;
  logic [1:0]        r_burst;
  logic [ID_W-1:0]   r_id;
  logic              r_load, r_load_last;

  // Read next-state and beat-load decode
  always_comb begin
    r_state_nxt = r_state;
    r_load      = 1'b0;
    r_load_addr = r_addr;
    r_load_last = 1'b0;
    r_addr_nxt  = next_addr(r_addr, r_len, r_size, r_burst);
    case (r_state)
      R_IDLE: begin
        if (arvalid_s0) begin
          if (RD_LAT <= 1) begin
            r_state_nxt = R_DATA;
            r_load      = 1'b1;
            r_load_addr = araddr_s0;
            r_load_last = (arlen_s0 == 8'd0);
          end else begin
            r_state_nxt = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        // Counter hits 0 as R_DATA is entered
        if (lat_cnt <= 3'd1) begin
          r_state_nxt = R_DATA;
          r_load      = 1'b1;
          r_load_last = (r_len == 8'd0);
        end
      end
      R_DATA: begin
        if (rready_s0) begin
          if (r_cnt == r_len) begin
            r_state_nxt = R_IDLE;
          end else begin
            r_load      = 1'b1;
            r_load_addr = r_addr_nxt;
            r_load_last = ((r_cnt + 8'd1) == r_len);
          end
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read state register
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) r_state <= R_IDLE;
    else                r_state <= r_state_nxt;
  end

  // Read burst tracking and registered R-channel outputs
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      arready_s0 <= 1'b1;
      rvalid_s0  <= 1'b0;
      rlast_s0   <= 1'b0;
      rdata_s0   <= '0;
      rid_s0     <= '0;
      rresp_s0   <= 2'b00;
      r_addr     <= '0;
      r_len      <= 8'd0;
      r_cnt      <= 8'd0;
      r_size     <= 3'd0;
      r_burst    <= 2'b00;
      r_id       <= '0;
      lat_cnt    <= 3'd0;
    end else begin
      arready_s0 <= (r_state_nxt == R_IDLE);
      rvalid_s0  <= (r_state_nxt == R_DATA);
      if (r_state == R_IDLE && arvalid_s0) begin
        r_addr  <= araddr_s0;
        r_len   <= arlen_s0;
        r_size  <= arsize_s0;
        r_burst <= arburst_s0;
        r_id    <= arid_s0;
        r_cnt   <= 8'd0;
        lat_cnt <= 3'(RD_LAT - 1);
      end
      if (r_state == R_WAIT) lat_cnt <= lat_cnt - 3'd1;
      if (r_state == R_DATA && rready_s0) begin
        r_cnt  <= r_cnt + 8'd1;
        r_addr <= r_addr_nxt;
      end
      // Beat payload only changes on a new beat, so it holds through stalls
      if (r_load) begin
        rdata_s0 <= is_oor(r_load_addr) ? '0 : mem[word_idx(r_load_addr)];
        rresp_s0 <= is_oor(r_load_addr) ? 2'b10 : 2'b00;
        rid_s0   <= (r_state == R_IDLE) ? arid_s0 : r_id;
        rlast_s0 <= r_load_last;
      end else if (r_state_nxt != R_DATA) begin
        rlast_s0 <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- write side
  w_state_t          w_state, w_state_nxt;
  logic [ADDR_W-1:0] w_addr, w_addr_nxt;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic [ID_W-1:0]   w_id;
  logic              w_err, w_beat, w_beat_oor;

  assign w_beat     = (w_state == W_DATA) && wvalid_s0;
  assign w_beat_oor = is_oor(w_addr);

  // Write next-state decode; the beat count alone ends the burst
  always_comb begin
    w_state_nxt = w_state;
    w_addr_nxt  = next_addr(w_addr, w_len, w_size, w_burst);
    case (w_state)
      W_IDLE:  if (awvalid_s0) w_state_nxt = W_DATA;
      W_DATA:  if (w_beat && w_cnt == w_len) w_state_nxt = W_RESP;
      W_RESP:  if (bready_s0) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write state register
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) w_state <= W_IDLE;
    else                w_state <= w_state_nxt;
  end

  // Write burst tracking and registered AW/W/B outputs
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      awready_s0 <= 1'b1;
      wready_s0  <= 1'b0;
      bvalid_s0  <= 1'b0;
      bid_s0     <= '0;
      bresp_s0   <= 2'b00;
      w_addr     <= '0;
      w_len      <= 8'd0;
      w_cnt      <= 8'd0;
      w_size     <= 3'd0;
      w_burst    <= 2'b00;
      w_id       <= '0;
      w_err      <= 1'b0;
    end else begin
      awready_s0 <= (w_state_nxt == W_IDLE);
      wready_s0  <= (w_state_nxt == W_DATA);
      bvalid_s0  <= (w_state_nxt == W_RESP);
      if (w_state == W_IDLE && awvalid_s0) begin
        w_addr  <= awaddr_s0;
        w_len   <= awlen_s0;
        w_size  <= awsize_s0;
        w_burst <= awburst_s0;
        w_id    <= awid_s0;
        w_cnt   <= 8'd0;
        w_err   <= 1'b0;
      end
      if (w_beat) begin
        w_cnt  <= w_cnt + 8'd1;
        w_addr <= w_addr_nxt;
        if (w_beat_oor) w_err <= 1'b1;
        if (w_cnt == w_len) begin
          bid_s0   <= w_id;
          bresp_s0 <= (w_err || w_beat_oor) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Storage: byte-strobed write; a same-cycle read sees the old word
  always_ff @(posedge pll_core_cpuclk) begin
    if (w_beat && !w_beat_oor) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (wstrb_s0[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata_s0[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_param.sv
`timescale 1ns/1ps
// Bench for axi_slave_mem_param: directed vector table, hand-written corner
// sequences and randomized bursts checked against a byte-level memory model.
module tb_axi_slave_mem_param;

  localparam int DW = 128, AW = 40, IW = 8, MAW = 12, LAT = 2;
  localparam int HIB = MAW + 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] araddr = '0, awaddr = '0;
  logic [IW-1:0] arid = '0, awid = '0, wid = '0;
  logic [7:0] arlen = '0, awlen = '0;
  logic [2:0] arsize = '0, awsize = '0;
  logic [1:0] arburst = '0, awburst = '0;
  logic arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic bready = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic arready, awready, wready, bvalid, rvalid, rlast;
  logic [IW-1:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;

  axi_slave_mem_param #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .MEM_AW(MAW), .RD_LAT(LAT)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_n),
    .araddr_s0(araddr), .arid_s0(arid), .arlen_s0(arlen), .arsize_s0(arsize),
    .arburst_s0(arburst), .arcache_s0(4'd0), .arprot_s0(3'd0), .arvalid_s0(arvalid),
    .arready_s0(arready),
    .awaddr_s0(awaddr), .awid_s0(awid), .awlen_s0(awlen), .awsize_s0(awsize),
    .awburst_s0(awburst), .awcache_s0(4'd0), .awprot_s0(3'd0), .awvalid_s0(awvalid),
    .awready_s0(awready),
    .wdata_s0(wdata), .wstrb_s0(wstrb), .wid_s0(wid), .wlast_s0(wlast),
    .wvalid_s0(wvalid), .wready_s0(wready),
    .bid_s0(bid), .bresp_s0(bresp), .bvalid_s0(bvalid), .bready_s0(bready),
    .rdata_s0(rdata), .rid_s0(rid), .rresp_s0(rresp), .rlast_s0(rlast),
    .rvalid_s0(rvalid), .rready_s0(rready)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;

  // Reference memory, stimulus and expectation buffers
  logic [DW-1:0] mdl [0:(1<<MAW)-1];
  logic [DW-1:0] wd [0:255];
  logic [15:0]   ws [0:255];
  logic [DW-1:0] exp_d [0:255];
  logic [1:0]    exp_resp [0:255];

  typedef struct {
    logic [AW-1:0] addr;
    int len, size, burst;
    int w [4];
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++; fails++;
    $display("FAIL %s timeout at cycle %0d", nm, cyc);
  endtask

  function automatic logic [DW-1:0] pat(input int w);
    return {32'hA000_0000 + 32'(w), 32'hB000_0000 + 32'(w),
            32'hC000_0000 + 32'(w), 32'hD000_0000 + 32'(w)};
  endfunction

  // Address of beat i computed directly from burst rules
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int len,
                                              input int size, input int burst, input int i);
    longint unsigned a64, step, wb, base, off;
    int s;
    a64 = 64'(a);
    s = (size > 4) ? 4 : size;
    step = 64'(1) << s;
    if (burst == 0) return a;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      wb = 64'(len + 1) * step;
      base = a64 - (a64 % wb);
      off = ((a64 - base) + 64'(i) * step) % wb;
      return AW'(base + off);
    end
    return AW'(a64 + 64'(i) * step);
  endfunction

  function automatic bit in_range(input logic [AW-1:0] a);
    return (a >> HIB) == '0;
  endfunction

  task automatic model_read_exp(input logic [AW-1:0] a, input int len, input int size, input int burst);
    logic [AW-1:0] ba;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(a, len, size, burst, i);
      exp_d[i]    = in_range(ba) ? mdl[int'(ba[HIB-1:4])] : '0;
      exp_resp[i] = in_range(ba) ? 2'b00 : 2'b10;
    end
  endtask

  // rmode: 0 rready held high, 1 toggling, 2 random
  task automatic do_read(input logic [AW-1:0] a, input int len, input int size, input int burst,
                         input logic [IW-1:0] id, input int rmode, input string tag, output int lat);
    int t, i, guard, first, lastc;
    lat = -1; first = -1; lastc = 0;
    @(negedge clk);
    araddr = a; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arid = id; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 100) begin @(negedge clk); guard++; end
    if (!arready) begin timeout({tag, "_ar"}); arvalid = 1'b0; return; end
    t = cyc;
    @(negedge clk);
    arvalid = 1'b0;
    i = 0; guard = 0;
    while (i <= len && guard < 600) begin
      case (rmode)
        0: rready = 1'b1;
        1: rready = ~rready;
        default: rready = ($urandom % 3) != 0;
      endcase
      if (rvalid) begin
        if (first < 0) first = cyc;
        chk({tag, "_rdata"}, 256'(rdata), 256'(exp_d[i]));
        chk({tag, "_rresp_rid_rlast"}, 256'({rresp, rid, rlast}), 256'({exp_resp[i], id, i == len}));
        if (rready) begin
          if (i == len) lastc = cyc;
          i++;
        end
      end
      @(negedge clk); guard++;
    end
    rready = 1'b0;
    if (i <= len) begin timeout({tag, "_rbeats"}); return; end
    lat = first - t;
    if (rmode == 0) begin
      chk({tag, "_back_to_back"}, 256'(lastc - first), 256'(len));
      chk({tag, "_arready_ret"}, 256'({arready, rvalid}), 256'(2'b10));
    end
  endtask

  // wmode: 0 wvalid held high, 1 random bubbles
  task automatic do_write(input logic [AW-1:0] a, input int len, input int size, input int burst,
                          input logic [IW-1:0] id, input int wmode, input string tag,
                          output logic [1:0] bresp_o);
    int i, guard;
    bit err;
    logic [AW-1:0] ba;
    bresp_o = 2'bxx; err = 0;
    @(negedge clk);
    awaddr = a; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awid = id; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 100) begin @(negedge clk); guard++; end
    if (!awready) begin timeout({tag, "_aw"}); awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    chk({tag, "_wready_after_aw"}, 256'(wready), 256'(1));
    i = 0; guard = 0;
    while (i <= len && guard < 600) begin
      wvalid = (wmode == 0) ? 1'b1 : (($urandom % 3) != 0);
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len);
      if (wvalid && wready) begin
        ba = beat_addr(a, len, size, burst, i);
        if (in_range(ba)) begin
          for (int b = 0; b < 16; b++)
            if (ws[i][b]) mdl[int'(ba[HIB-1:4])][b*8 +: 8] = wd[i][b*8 +: 8];
        end else err = 1;
        i++;
      end
      @(negedge clk); guard++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (i <= len) begin timeout({tag, "_wbeats"}); return; end
    chk({tag, "_bvalid_after_last"}, 256'({bvalid, wready}), 256'(2'b10));
    chk({tag, "_bid_bresp"}, 256'({bid, bresp}), 256'({id, err ? 2'b10 : 2'b00}));
    bresp_o = bresp;
    repeat ($urandom % 3) @(negedge clk);
    bready = 1'b1;
    guard = 0;
    while (!bvalid && guard < 100) begin @(negedge clk); guard++; end
    if (!bvalid) begin timeout({tag, "_b"}); bready = 1'b0; return; end
    @(negedge clk);
    bready = 1'b0;
    chk({tag, "_awready_after_b"}, 256'({awready, bvalid}), 256'(2'b10));
  endtask

  task automatic set_vec(input int k, input logic [AW-1:0] a, input int len, input int size,
                         input int burst, input int w0, input int w1, input int w2, input int w3);
    tbl[k].addr = a; tbl[k].len = len; tbl[k].size = size; tbl[k].burst = burst;
    tbl[k].w[0] = w0; tbl[k].w[1] = w1; tbl[k].w[2] = w2; tbl[k].w[3] = w3;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, len, size, burst, g;
    logic [1:0] br;
    logic [AW-1:0] a;

    // Burst-address vectors: expected word index of each beat
    set_vec(0, 40'h30,  3, 4, 2, 3, 0, 1, 2);    // WRAP 4x16
    set_vec(1, 40'h40,  2, 4, 0, 4, 4, 4, 0);    // FIXED
    set_vec(2, 40'h200, 3, 4, 1, 32, 33, 34, 35); // INCR
    set_vec(3, 40'h18,  3, 3, 2, 1, 0, 0, 1);    // WRAP 4x8 bytes
    set_vec(4, 40'h3C,  1, 5, 2, 3, 2, 0, 0);    // size above bus width, WRAP
    set_vec(5, 40'h70,  2, 4, 2, 7, 8, 9, 0);    // WRAP len 2 acts as INCR
    set_vec(6, 40'h100, 1, 4, 3, 16, 17, 0, 0);  // burst 11 acts as INCR

    for (int k = 0; k < (1 << MAW); k++) mdl[k] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_handshakes", 256'({arready, awready, wready, bvalid, rvalid, rlast}), 256'(6'b110000));
    chk("reset_ids_resps", 256'({bid, rid, bresp, rresp}), 256'(0));
    chk("reset_rdata", 256'(rdata), 256'(0));
    rst_n = 1'b1;

    // Fill words 0..63 with a known pattern
    for (int i = 0; i < 64; i++) begin wd[i] = pat(i); ws[i] = 16'hFFFF; end
    do_write(40'h0, 63, 4, 1, 8'h01, 0, "init", br);

    // Table-driven burst address walk
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i <= tbl[k].len; i++) begin
        exp_d[i] = pat(tbl[k].w[i]); exp_resp[i] = 2'b00;
      end
      do_read(tbl[k].addr, tbl[k].len, tbl[k].size, tbl[k].burst, 8'(8'h40 + k), 0, "vec", lat);
      chk("vec_latency", 256'(lat), 256'(LAT));
    end

    // INCR 4-beat write then read back
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(i); ws[i] = 16'hFFFF; end
    do_write(40'h200, 3, 4, 1, 8'h5A, 0, "incr_wr", br);
    chk("incr_wr_bresp", 256'(br), 256'(2'b00));
    for (int i = 0; i < 4; i++) begin exp_d[i] = DW'(i); exp_resp[i] = 2'b00; end
    do_read(40'h200, 3, 4, 1, 8'hA5, 0, "incr_rd", lat);

    // Partial strobe, then single-beat read latency
    wd[0] = '1; ws[0] = 16'hFFFF;
    do_write(40'h100, 0, 4, 1, 8'h11, 0, "full_wr", br);
    wd[0] = '0; ws[0] = 16'h0001;
    do_write(40'h100, 0, 4, 1, 8'h12, 0, "strb_wr", br);
    exp_d[0] = {{120{1'b1}}, 8'h00}; exp_resp[0] = 2'b00;
    do_read(40'h100, 0, 4, 1, 8'h33, 0, "single_rd", lat);
    chk("single_rd_latency", 256'(lat), 256'(LAT));

    // Out-of-range write and read
    wd[0] = {4{32'hDEAD_BEEF}}; ws[0] = 16'hFFFF;
    do_write(40'h1 << HIB, 0, 4, 1, 8'h77, 0, "oor_wr", br);
    chk("oor_wr_bresp", 256'(br), 256'(2'b10));
    exp_d[0] = pat(0); exp_resp[0] = 2'b00;
    do_read(40'h0, 0, 4, 1, 8'h78, 0, "oor_alias_unchanged", lat);
    exp_d[0] = '0; exp_resp[0] = 2'b10;
    do_read(40'h1 << HIB, 0, 4, 1, 8'h79, 0, "oor_rd", lat);

    // Concurrent stalled 8-beat read and 4-beat write (same-cycle AR/AW)
    for (int i = 0; i < 8; i++) begin exp_d[i] = pat(i); exp_resp[i] = 2'b00; end
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'(($urandom)); end
    fork
      begin int l2; do_read(40'h0, 7, 4, 1, 8'hC1, 1, "conc_rd", l2); end
      begin logic [1:0] b2; do_write(40'h300, 3, 4, 1, 8'hC2, 1, "conc_wr", b2); end
    join
    model_read_exp(40'h300, 3, 4, 1);
    do_read(40'h300, 3, 4, 1, 8'hC3, 2, "conc_chk", lat);

    // Randomized bursts against the model
    for (int n = 0; n < 40; n++) begin
      len = (($urandom % 3) == 0) ? ((2 << ($urandom % 4)) - 1) : int'($urandom % 16);
      size = int'($urandom % 6);
      burst = int'($urandom % 4);
      a = AW'($urandom % 768);
      if (($urandom % 8) == 0) a = a | (40'h1 << HIB);
      if ($urandom % 2) begin
        for (int i = 0; i <= len; i++) begin
          wd[i] = {$urandom, $urandom, $urandom, $urandom};
          ws[i] = (($urandom % 4) == 0) ? 16'hFFFF : 16'($urandom);
        end
        do_write(a, len, size, burst, 8'($urandom), 1, "rnd_wr", br);
      end else begin
        model_read_exp(a, len, size, burst);
        do_read(a, len, size, burst, 8'($urandom), 2, "rnd_rd", lat);
      end
    end

    // Reset asserted in the middle of a read burst
    @(negedge clk);
    araddr = 40'h0; arlen = 8'd7; arsize = 3'd4; arburst = 2'b01; arid = 8'h5C; arvalid = 1'b1;
    g = 0;
    while (!arready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    g = 0;
    while (!rvalid && g < 50) begin @(negedge clk); g++; end
    if (!rvalid) timeout("rst_mid_rvalid");
    repeat (2) @(negedge clk);
    rst_n = 1'b0; rready = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_rvalid_arready", 256'({rvalid, rlast, arready, awready, wready, bvalid}), 256'(6'b001100));
    @(negedge clk);
    rst_n = 1'b1;
    exp_d[0] = pat(0); exp_resp[0] = 2'b00;
    do_read(40'h0, 0, 4, 1, 8'h5D, 0, "after_rst", lat);
    chk("after_rst_latency", 256'(lat), 256'(LAT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem_param.md
# axi_slave_mem_param

Parametrised AXI3 slave memory model for the CPU test bench; the next generation of the 128-bit single-FSM slave. Read and write channels run concurrently. It supports FIXED/INCR/WRAP bursts of any legal length and size, a configurable read latency, and SLVERR for out-of-range accesses. It sits on the bench bus fabric in place of the s0 slave, with storage in an internal dual-port behavioural array.

## Interface
Parameters:
- DATA_W, 128, data bus width in bits: 64, 128 or 256. NB = DATA_W/8 bytes per beat.
- ADDR_W, 40, AXI address width.
- ID_W, 8, AXI ID width.
- MEM_AW, 21, log2 of the number of DATA_W-wide memory words.
- RD_LAT, 2, cycles from AR handshake to first rvalid, 1..8.

Ports (all `_s0` AXI ports are synchronous to pll_core_cpuclk):
- pll_core_cpuclk  in  1  the only clock; all logic on the rising edge.
- pad_cpu_rst_b  in  1  asynchronous active-low reset.
- araddr_s0/awaddr_s0  in  ADDR_W  burst start address.
- arid_s0/awid_s0  in  ID_W  transaction ID.
- arlen_s0/awlen_s0  in  8  beats minus 1.
- arsize_s0/awsize_s0  in  3  log2 bytes per beat.
- arburst_s0/awburst_s0  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
- arcache_s0/awcache_s0, arprot_s0/awprot_s0  in  4/3  ignored.
- arvalid_s0/awvalid_s0  in  1  address valid.
- arready_s0/awready_s0  out  1  address ready.
- wdata_s0  in  DATA_W  write data.
- wstrb_s0  in  NB  byte strobes.
- wid_s0  in  ID_W  ignored; write data is in order.
- wlast_s0, wvalid_s0  in  1  write last / write valid.
- wready_s0  out  1  write ready.
- bid_s0  out  ID_W  response ID.
- bresp_s0  out  2  write response.
- bvalid_s0  out  1  response valid.
- bready_s0  in  1  response ready.
- rdata_s0  out  DATA_W  read data.
- rid_s0  out  ID_W  read ID.
- rresp_s0  out  2  read response.
- rlast_s0, rvalid_s0  out  1  read last / read valid.
- rready_s0  in  1  read ready.

## Operation
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - arready_s0=1 only in R_IDLE.
  - On AR handshake: latch id, len, size, burst and address; clear beat count; go to R_WAIT with a latency counter set to RD_LAT-1.
  - When the counter reaches 0, go to R_DATA with rvalid=1 and rdata taken from the current beat address.
  - On each R handshake: beat count +1 and the address advances.
    - If the beat was not the last, the next beat is valid in the following cycle (back-to-back).
    - If the beat was the last (count==len), return to R_IDLE.
  - rdata, rid and rresp are held stable while rvalid && !rready.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - awready_s0=1 only in W_IDLE.
  - On AW handshake: latch the burst fields; go to W_DATA.
  - In W_DATA, wready_s0=1. Each beat writes the bytes whose wstrb bit is 1; bytes with strobe 0 are unchanged.
  - The beat where count==awlen ends the burst and moves to W_RESP. wlast_s0 is not used to detect the end of the burst.
  - In W_RESP: bvalid=1, bid=latched awid. On B handshake return to W_IDLE.
- Beat address:
  - S = min(size, log2 NB); step = 1<<S.
  - FIXED: the address is constant.
  - INCR: address += step, computed mod 2^ADDR_W.
  - WRAP: when len is in {1,3,7,15}, wrap within an aligned window of (len+1)<<S bytes; for any other len, behave as INCR.
  - Burst type 11 behaves as INCR.
  - The memory word index is address[log2 NB + MEM_AW - 1 : log2 NB]. Full-width data is always returned; the master selects the byte lanes.
- Range check (per beat): if any address bit at or above log2 NB + MEM_AW is set, the beat is out of range.
  - Read beat: rresp=2'b10 for that beat, rdata=0.
  - Write beat: the memory write is suppressed and a sticky error is set; bresp=2'b10 if any beat of the burst was out of range, else 2'b00.
- A read and a write to the same word in the same cycle: the read returns the old data.

## Timing
- Reset values of outputs: arready_s0=1, awready_s0=1, wready_s0=0, bvalid_s0=0, rvalid_s0=0, rlast_s0=0, bid/rid/bresp/rresp/rdata=0. Both FSMs reset to IDLE. Memory contents are not reset.
- Reset asserted mid-burst: both FSMs return to IDLE immediately. A partially written burst keeps the beats already written.
- Read latency: AR handshake at cycle T → rvalid=1 at T+RD_LAT. With rready held high, an N-beat burst finishes at T+RD_LAT+N-1, and arready returns to 1 at T+RD_LAT+N.
- Write: AW handshake at T → wready=1 at T+1. The last W beat at cycle L → bvalid=1 at L+1. After the B handshake at cycle B, awready=1 at B+1.
- rlast_s0 = rvalid && count==len.
- The two channels are fully independent: AR and AW handshakes may occur in the same cycle.

## Test plan
- Single read with RD_LAT=2, DATA_W=128: AR addr 0x100 len 0 at T → rvalid at T+2, rlast=1, rresp=0, rid=AR id, rdata = the word previously written.
- INCR write of 4 beats to 0x200, strobes 0xFFFF, data 0..3, then read back 4 beats → rdata 0,1,2,3, with back-to-back rvalid while rready=1; bresp=0, bid=awid.
- WRAP read at 0x30, len 3, size 4 → beat addresses 0x30, 0x00, 0x10, 0x20. FIXED read of len 2 → the same word three times.
- Partial strobe: write 0xFF..FF to a word, then write with wstrb=0x0001 and data 0 → read returns 0xFF..FF00.
- Out-of-range: AW address 2^(4+MEM_AW) → memory unchanged, bresp=2'b10. Read at the same address → rresp=2'b10, rdata=0.
- Concurrency and reset: an 8-beat read with rready toggling, overlapping a 4-beat write → data held stable while stalled, both responses correct. Assert pad_cpu_rst_b low mid-read → rvalid=0 and arready=1 on the next edge.
